// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 3-stage core (F | DE | MW).
// Drives the PC enable and the enable/flush controls of the F/DE and DE/MW
// pipeline registers. It detects load-use and ALU-use hazards, freezes the
// pipeline while data memory is busy, squashes wrong-path fetches, counts
// stall cycles and flags memory timeouts.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rs1_de_i/rs2_de_i DE-stage source registers
//   rd_mw_i           MW-stage destination register
//   reg_wr_mw_i       MW instruction writes rd
//   is_load_mw_i      MW instruction is a load
//   br_taken_de_i     DE resolved a taken branch/jump
//   dmem_req_mw_i     MW issues a data-memory access
//   dmem_ready_i      data memory completes the access this cycle
//   en_pc_o           PC load enable
//   en_f_de_o         F/DE enable, flush_f_de_o loads a NOP
//   en_de_mw_o        DE/MW enable, flush_de_mw_o loads a bubble
//   fwd_a_o/fwd_b_o   select the MW ALU result for operand A/B
//   stall_cnt_o       saturating count of cycles with en_pc_o low
//   mem_err_o         sticky flag: memory wait exceeded MEM_TIMEOUT
//
// The enable/flush/forward outputs must act in the same cycle as the hazard
// they respond to, so they are combinational decodes of the current inputs;
// stall_cnt_o and mem_err_o come straight from registers.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_de_i,
    input  logic [4:0]       rs2_de_i,
    input  logic [4:0]       rd_mw_i,
    input  logic             reg_wr_mw_i,
    input  logic             is_load_mw_i,
    input  logic             br_taken_de_i,
    input  logic             dmem_req_mw_i,
    input  logic             dmem_ready_i,
    output logic             en_pc_o,
    output logic             en_f_de_o,
    output logic             flush_f_de_o,
    output logic             en_de_mw_o,
    output logic             flush_de_mw_o,
    output logic             fwd_a_o,
    output logic             fwd_b_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             mem_err_o
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               mem_err_q, mem_err_d;

    logic dep1, dep2, load_use, mem_stall;
    logic en_pc, en_f_de, flush_f_de, en_de_mw, flush_de_mw, fwd_a, fwd_b;

    // Hazard terms; x0 is never a real dependency.
    always_comb begin
        dep1      = reg_wr_mw_i && (rd_mw_i != 5'd0) && (rd_mw_i == rs1_de_i);
        dep2      = reg_wr_mw_i && (rd_mw_i != 5'd0) && (rd_mw_i == rs2_de_i);
        load_use  = is_load_mw_i && (dep1 || dep2);
        mem_stall = dmem_req_mw_i && !dmem_ready_i;
    end

    // State register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Next state, pipeline controls and counter updates.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        en_pc       = 1'b1;
        en_f_de     = 1'b1;
        flush_f_de  = 1'b0;
        en_de_mw    = 1'b1;
        flush_de_mw = 1'b0;
        fwd_a       = dep1 && !is_load_mw_i;
        fwd_b       = dep2 && !is_load_mw_i;

        // LOAD_STALL lasts one cycle and otherwise behaves exactly like RUN.
        // The cycle that leaves MEM_WAIT also follows RUN rules, so a load
        // completing under a dependent DE instruction still gets its bubble.
        unique case (state_q)
            ST_MEM_WAIT: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT)) begin
                        wait_cnt_d = WAIT_W'(wait_cnt_q + 1'b1);
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                end else if (load_use) begin
                    state_d = ST_LOAD_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                end else if (load_use) begin
                    state_d = ST_LOAD_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase

        // Priority: memory freeze > load-use bubble > branch squash.
        if (mem_stall) begin
            en_pc    = 1'b0;
            en_f_de  = 1'b0;
            en_de_mw = 1'b0;
        end else if (load_use) begin
            en_pc       = 1'b0;
            en_f_de     = 1'b0;
            flush_de_mw = 1'b1;
        end else if (br_taken_de_i) begin
            flush_f_de = 1'b1;
        end

        if (rst) begin
            en_pc       = 1'b0;
            en_f_de     = 1'b0;
            en_de_mw    = 1'b0;
            flush_f_de  = 1'b1;
            flush_de_mw = 1'b1;
            fwd_a       = 1'b0;
            fwd_b       = 1'b0;
        end

        mem_err_d = mem_err_q || (wait_cnt_d == WAIT_W'(MEM_TIMEOUT));

        if (!en_pc && !(&stall_cnt_q)) begin
            stall_cnt_d = CNT_W'(stall_cnt_q + 1'b1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    assign en_pc_o       = en_pc;
    assign en_f_de_o     = en_f_de;
    assign flush_f_de_o  = flush_f_de;
    assign en_de_mw_o    = en_de_mw;
    assign flush_de_mw_o = flush_de_mw;
    assign fwd_a_o       = fwd_a;
    assign fwd_b_o       = fwd_b;
    assign stall_cnt_o   = stall_cnt_q;
    assign mem_err_o     = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed then random
// stimulus and pushes the reference expectation; a monitor pops and compares
// on the falling edge.
module tb_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CW      = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    rs1 = '0, rs2 = '0, rd = '0;
    logic          wr = 1'b0, ld = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
    logic          en_pc, en_f_de, flush_f_de, en_de_mw, flush_de_mw, fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;
    logic          mem_err;

    hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_de_i(rs1), .rs2_de_i(rs2), .rd_mw_i(rd),
        .reg_wr_mw_i(wr), .is_load_mw_i(ld), .br_taken_de_i(br),
        .dmem_req_mw_i(req), .dmem_ready_i(rdy),
        .en_pc_o(en_pc), .en_f_de_o(en_f_de), .flush_f_de_o(flush_f_de),
        .en_de_mw_o(en_de_mw), .flush_de_mw_o(flush_de_mw),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
        .stall_cnt_o(stall_cnt), .mem_err_o(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]    ctl;   // {en_pc,en_f_de,flush_f_de,en_de_mw,flush_de_mw,fwd_a,fwd_b}
        logic [CW-1:0] cnt;
        logic          err;
        bit            chk_regs;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state: what the registered outputs should show now.
    int  m_cnt     = 0;
    bit  m_err     = 1'b0;
    int  m_streak  = 0;    // consecutive memory-stalled cycles
    bit  m_seen_rst = 1'b0;

    // Apply one cycle of inputs and record the expected response.
    task automatic cycle(input string tag, input bit r, input int a, input int b, input int d,
                         input bit w, input bit l, input bit bt, input bit q, input bit y);
        exp_t e;
        bit d1, d2, stall, lu;
        @(posedge clk);
        #1;
        rst = r; rs1 = 5'(a); rs2 = 5'(b); rd = 5'(d);
        wr = w; ld = l; br = bt; req = q; rdy = y;

        d1    = w && (d != 0) && (d == a);
        d2    = w && (d != 0) && (d == b);
        stall = q && !y;
        lu    = l && (d1 || d2);
        if (r)          e.ctl = 7'b0010100;
        else if (stall) e.ctl = {5'b00000, d1 && !l, d2 && !l};
        else if (lu)    e.ctl = {5'b00011, 2'b00};
        else if (bt)    e.ctl = {5'b11110, d1 && !l, d2 && !l};
        else            e.ctl = {5'b11010, d1 && !l, d2 && !l};
        e.cnt      = CW'(m_cnt);
        e.err      = m_err;
        e.chk_regs = m_seen_rst;
        e.tag      = tag;
        exp_q.push_back(e);

        // Advance the reference to the value after this clock edge.
        if (r) begin
            m_cnt = 0; m_err = 1'b0; m_streak = 0; m_seen_rst = 1'b1;
        end else begin
            if (e.ctl[6] == 1'b0 && m_cnt < (1 << CW) - 1) m_cnt++;
            m_streak = stall ? m_streak + 1 : 0;
            // First stalled cycle is the entry; TIMEOUT more wait cycles trip the flag.
            if (m_streak >= int'(TIMEOUT) + 1) m_err = 1'b1;
        end
    endtask

    // Monitor: every cycle the DUT presents a full set of controls.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({en_pc, en_f_de, flush_f_de, en_de_mw, flush_de_mw, fwd_a, fwd_b} === e.ctl)
                    n_pass++;
                else
                    $display("FAIL %s ctl: got %b want %b", e.tag,
                             {en_pc, en_f_de, flush_f_de, en_de_mw, flush_de_mw, fwd_a, fwd_b}, e.ctl);
                if (e.chk_regs) begin
                    n_checks += 2;
                    if (stall_cnt === e.cnt) n_pass++;
                    else $display("FAIL %s stall_cnt: got %0d want %0d", e.tag, stall_cnt, e.cnt);
                    if (mem_err === e.err) n_pass++;
                    else $display("FAIL %s mem_err: got %b want %b", e.tag, mem_err, e.err);
                end
            end
        end
    end

    initial begin
        // Reset for two cycles.
        cycle("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ALU-use forwarding, and x0 never forwards.
        cycle("fwd_a",  0, 5, 1, 5, 1, 0, 0, 0, 0);
        cycle("fwd_x0", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cycle("fwd_b",  0, 2, 9, 9, 1, 0, 0, 0, 0);
        // Load-use: one bubble, then the load has retired.
        cycle("ld_use", 0, 1, 7, 7, 1, 1, 0, 0, 0);
        cycle("ld_done", 0, 1, 7, 0, 0, 0, 0, 0, 0);
        // Memory wait of three cycles, with a branch that must be ignored.
        cycle("mw0", 0, 0, 0, 3, 1, 1, 0, 1, 0);
        cycle("mw1", 0, 0, 0, 3, 1, 1, 1, 1, 0);
        cycle("mw2", 0, 0, 0, 3, 1, 1, 0, 1, 0);
        cycle("mw_rdy", 0, 0, 0, 3, 1, 1, 0, 1, 1);
        cycle("post_mw", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Taken branch squashes the fetch.
        cycle("br", 0, 1, 2, 0, 0, 0, 1, 0, 0);
        cycle("br_ld_use", 0, 4, 0, 4, 1, 1, 1, 0, 0);
        cycle("after_br", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Long wait: timeout and stall counter saturation.
        for (int i = 0; i < 14; i++) cycle("timeout", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle("to_rdy", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("err_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("err_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("err_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Mid-wait reset returns to a clean state.
        cycle("mw_a", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle("mw_b", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle("mw_rst", 1, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle("mw_clean", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Randomised traffic over a small register range to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            bit q;
            q = ($urandom_range(0, 2) == 0);
            cycle("rand", ($urandom_range(0, 99) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), q,
                  q ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
